// File: rtl/spi_cmd_receiver_pkg.sv
// Shared constants for the SPI command receiver, the wave generator top and the bench.
package spi_cmd_receiver_pkg;
   localparam int FRAME_BITS_DEF = 16;
   localparam int CMD_BITS       = 8;
   localparam int CMD_WR_BIT     = 7;

   localparam logic [1:0] ADDR_PHASE  = 2'd0;
   localparam logic [1:0] ADDR_AMPL   = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous input; reset value sets the idle level.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);
   logic r_meta, r_sync;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= d_i;
         r_sync <= r_meta;
      end
   end

   assign q_o = r_sync;
endmodule

// File: rtl/spi_cmd_receiver.sv
// SPI mode-0 slave: 8-bit command + 8-bit data frames writing phase/amplitude/control,
// with readback of the addressed register on sdo during the data byte.
module spi_cmd_receiver
   import spi_cmd_receiver_pkg::*;
#(
   parameter int FRAME_BITS = FRAME_BITS_DEF
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       sclk_i,
   input  logic       cs_n_i,
   input  logic       sdi_i,
   output logic       sdo_o,
   output logic [7:0] data_o,
   output logic       set_phase_strobe_o,
   output logic       set_amplitude_strobe_o,
   output logic       enable_o,
   output logic [1:0] waveform_o,
   output logic       frame_error_o
);
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SHIFT   = 2'd1;
   localparam logic [1:0] ST_WAIT_CS = 2'd2;

   logic       w_sclk_s, w_cs_s, w_sdi_s;
   logic       w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
   logic [7:0] w_byte, w_rb_sel;
   logic       w_last_bit, w_cmd_bit;

   logic [1:0] r_state;
   logic [4:0] r_bitcnt;
   logic [6:0] r_shift;
   logic       r_cmd_wr;
   logic [1:0] r_cmd_addr;
   logic [7:0] r_rb;
   logic       r_rb_act, r_sdo;
   logic [7:0] r_data, r_phase, r_ampl, r_err_cnt;
   logic       r_en;
   logic [1:0] r_wf;
   logic       r_ph_stb, r_am_stb, r_ferr;
   logic       r_sclk_d, r_cs_d;
   logic [1:0] r_settle;
   logic       r_armed;

   sync_2ff #(.RST_VAL(1'b0)) u_sync_sclk (.clk_i(clk_i), .rst_i(rst_i), .d_i(sclk_i), .q_o(w_sclk_s));
   sync_2ff #(.RST_VAL(1'b1)) u_sync_cs   (.clk_i(clk_i), .rst_i(rst_i), .d_i(cs_n_i), .q_o(w_cs_s));
   sync_2ff #(.RST_VAL(1'b0)) u_sync_sdi  (.clk_i(clk_i), .rst_i(rst_i), .d_i(sdi_i),  .q_o(w_sdi_s));

   assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
   assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
   assign w_cs_rise   = w_cs_s & ~r_cs_d;
   assign w_cs_fall   = ~w_cs_s & r_cs_d;

   assign w_byte     = {r_shift, w_sdi_s};
   assign w_last_bit = (r_bitcnt == 5'(FRAME_BITS - 1));
   assign w_cmd_bit  = (r_bitcnt == 5'(CMD_BITS - 1));

   always_comb begin
      w_rb_sel = 8'h00;
      case (w_byte[1:0])
         ADDR_PHASE:  w_rb_sel = r_phase;
         ADDR_AMPL:   w_rb_sel = r_ampl;
         ADDR_CTRL:   w_rb_sel = {5'b0, r_en, r_wf};
         ADDR_STATUS: w_rb_sel = r_err_cnt;
         default:     w_rb_sel = 8'h00;
      endcase
   end

   // The cs_n synchronizer resets high; wait until it shows the real pin level and
   // that level is high before honouring a falling edge, so a frame cut by reset is not resumed.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sclk_d <= 1'b0;
         r_cs_d   <= 1'b1;
         r_settle <= 2'd0;
         r_armed  <= 1'b0;
      end else begin
         r_sclk_d <= w_sclk_s;
         r_cs_d   <= w_cs_s;
         if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
         if (r_settle == 2'd3 && w_cs_s) r_armed <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= ST_IDLE;
         r_bitcnt   <= '0;
         r_shift    <= '0;
         r_cmd_wr   <= 1'b0;
         r_cmd_addr <= '0;
         r_rb       <= '0;
         r_rb_act   <= 1'b0;
         r_sdo      <= 1'b0;
         r_data     <= '0;
         r_phase    <= '0;
         r_ampl     <= '0;
         r_err_cnt  <= '0;
         r_en       <= 1'b0;
         r_wf       <= 2'b00;
         r_ph_stb   <= 1'b0;
         r_am_stb   <= 1'b0;
         r_ferr     <= 1'b0;
      end else begin
         r_ph_stb <= 1'b0;
         r_am_stb <= 1'b0;
         r_ferr   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_sdo <= 1'b0;
               if (w_cs_fall && r_armed) begin
                  r_state  <= ST_SHIFT;
                  r_bitcnt <= '0;
                  r_rb_act <= 1'b0;
               end
            end
            ST_SHIFT: begin
               if (w_sclk_rise) begin
                  r_shift  <= w_byte[6:0];
                  r_bitcnt <= r_bitcnt + 5'd1;
                  if (w_cmd_bit) begin
                     r_cmd_wr   <= w_byte[CMD_WR_BIT];
                     r_cmd_addr <= w_byte[1:0];
                     r_rb       <= w_rb_sel;
                     r_rb_act   <= 1'b1;
                  end
               end else if (w_sclk_fall && r_rb_act) begin
                  r_sdo <= r_rb[7];
                  r_rb  <= {r_rb[6:0], 1'b0};
               end
               // Completing the frame wins over a coincident cs_n release.
               if (w_sclk_rise && w_last_bit) begin
                  r_sdo   <= 1'b0;
                  r_state <= w_cs_rise ? ST_IDLE : ST_WAIT_CS;
                  if (r_cmd_wr) begin
                     case (r_cmd_addr)
                        ADDR_PHASE: begin
                           r_data   <= w_byte;
                           r_phase  <= w_byte;
                           r_ph_stb <= 1'b1;
                        end
                        ADDR_AMPL: begin
                           r_data   <= w_byte;
                           r_ampl   <= w_byte;
                           r_am_stb <= 1'b1;
                        end
                        ADDR_CTRL: begin
                           r_en <= w_byte[2];
                           r_wf <= w_byte[1:0];
                        end
                        default: ;
                     endcase
                  end
               end else if (w_cs_rise) begin
                  r_sdo     <= 1'b0;
                  r_state   <= ST_IDLE;
                  r_ferr    <= 1'b1;
                  r_err_cnt <= sat_inc8(r_err_cnt);
               end
            end
            ST_WAIT_CS: begin
               r_sdo <= 1'b0;
               if (w_cs_rise) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign sdo_o                  = r_sdo;
   assign data_o                 = r_data;
   assign set_phase_strobe_o     = r_ph_stb;
   assign set_amplitude_strobe_o = r_am_stb;
   assign enable_o               = r_en;
   assign waveform_o             = r_wf;
   assign frame_error_o          = r_ferr;
endmodule
